// File: rtl/cpu_mem_if.sv
// Bus bundle for cpu_mem: two read ports, one byte-enabled write port, status flags.
interface cpu_mem_if;
  logic [31:0] mem_r1_addr;
  logic [31:0] mem_r1_data;
  logic [31:0] mem_r2_addr;
  logic [31:0] mem_r2_data;
  logic        mem_w_enable;
  logic [31:0] mem_w_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_w_data;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output mem_r1_addr, mem_r2_addr, mem_w_enable, mem_w_addr, mem_byte_en, mem_w_data,
    input  mem_r1_data, mem_r2_data, mem_ready, mem_err
  );

  modport slave (
    input  mem_r1_addr, mem_r2_addr, mem_w_enable, mem_w_addr, mem_byte_en, mem_w_data,
    output mem_r1_data, mem_r2_data, mem_ready, mem_err
  );
endinterface

// File: rtl/cpu_mem.sv
// Two-read/one-write word memory with power-up clear sweep and sticky error flag.
// Define CPU_MEM_BYPASS_EN to forward same-cycle write data to reads of the same word.
//
// state   | meaning
// S_CLEAR | zeroing one word per cycle, not ready, accesses ignored
// S_RUN   | normal read/write service until rst
module cpu_mem #(
  parameter int ADDR_W = 10
) (
  input  logic      clk,
  input  logic      rst,
  cpu_mem_if.slave  bus
);

`ifdef CPU_MEM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       r1_q, r2_q, r1_next, r2_next, w_new;
  logic              err_q;
  logic              run, wr_hit, wr_ok, wr_bad, rd_bad;
  logic [ADDR_W-1:0] w_idx, r1_idx, r2_idx;

  function automatic logic oob(input logic [31:0] a);
    return (a >> (ADDR_W + 2)) != 32'd0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) m[8*b +: 8] = nw[8*b +: 8];
    return m;
  endfunction

  assign run    = (state == S_RUN);
  assign w_idx  = bus.mem_w_addr[ADDR_W+1:2];
  assign r1_idx = bus.mem_r1_addr[ADDR_W+1:2];
  assign r2_idx = bus.mem_r2_addr[ADDR_W+1:2];

  // A zero byte mask is a no-op even when the address would otherwise be illegal.
  assign wr_hit = run && bus.mem_w_enable && (bus.mem_byte_en != 4'b0000);
  assign wr_ok  = wr_hit && !oob(bus.mem_w_addr) && (bus.mem_w_addr[1:0] == 2'b00);
  assign wr_bad = wr_hit && !wr_ok;
  assign rd_bad = run && (oob(bus.mem_r1_addr) || oob(bus.mem_r2_addr));
  assign w_new  = merge(mem[w_idx], bus.mem_w_data, bus.mem_byte_en);

  always_comb begin
    r1_next = 32'h0;
    r2_next = 32'h0;
    if (run) begin
      if (!oob(bus.mem_r1_addr))
        r1_next = (BYPASS && wr_ok && (r1_idx == w_idx)) ? w_new : mem[r1_idx];
      if (!oob(bus.mem_r2_addr))
        r2_next = (BYPASS && wr_ok && (r2_idx == w_idx)) ? w_new : mem[r2_idx];
    end
  end

  // Storage has no reset; the clear sweep provides the known contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run)
        mem[clr_cnt] <= 32'h0;
      else if (wr_ok)
        for (int b = 0; b < 4; b++)
          if (bus.mem_byte_en[b]) mem[w_idx][8*b +: 8] <= bus.mem_w_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      r1_q    <= 32'h0;
      r2_q    <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      r1_q <= r1_next;
      r2_q <= r2_next;
      if (state == S_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        if (clr_cnt == '1) state <= S_RUN;
      end
      if (rd_bad || wr_bad) err_q <= 1'b1;
    end
  end

  assign bus.mem_r1_data = r1_q;
  assign bus.mem_r2_data = r2_q;
  assign bus.mem_ready   = run;
  assign bus.mem_err     = err_q;

endmodule

// File: tb/tb_cpu_mem.sv
// Scoreboard bench for cpu_mem: random and directed traffic against a word-array reference model.
module tb_cpu_mem;
  localparam int AW = 8;
  localparam int NW = 1 << AW;
  localparam logic [31:0] BYTES = 32'(NW * 4);
`ifdef CPU_MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_mem_if bus();
  cpu_mem #(.ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [NW];
  int          clear_left = 0;
  bit          m_err = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic bit m_oob(input logic [31:0] a);
    return a >= BYTES;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Drive one cycle of stimulus and predict what the outputs show after the next rising edge.
  task automatic step(input bit r, input logic [31:0] a1, input logic [31:0] a2, input bit we,
                      input logic [31:0] wa, input logic [3:0] be, input logic [31:0] wd);
    exp_t        e;
    bit          wr_ok;
    logic [31:0] merged;
    int          wi;
    rst              = r;
    bus.mem_r1_addr  = a1;
    bus.mem_r2_addr  = a2;
    bus.mem_w_enable = we;
    bus.mem_w_addr   = wa;
    bus.mem_byte_en  = be;
    bus.mem_w_data   = wd;
    e = '0;
    if (r) begin
      for (int i = 0; i < NW; i++) mdl[i] = 32'h0;
      clear_left = NW;
      m_err = 1'b0;
    end else if (clear_left > 0) begin
      clear_left--;
      e.rdy = (clear_left == 0);
      e.err = m_err;
    end else begin
      wr_ok  = we && be != 4'h0 && !m_oob(wa) && (wa % 4 == 0);
      if (we && be != 4'h0 && !wr_ok) m_err = 1'b1;
      wi     = wr_ok ? int'(wa / 4) : 0;
      merged = m_merge(mdl[wi], wd, be);
      if (m_oob(a1)) begin
        m_err = 1'b1;
      end else begin
        e.r1 = (BYP && wr_ok && a1 / 4 == wa / 4) ? merged : mdl[int'(a1 / 4)];
      end
      if (m_oob(a2)) begin
        m_err = 1'b1;
      end else begin
        e.r2 = (BYP && wr_ok && a2 / 4 == wa / 4) ? merged : mdl[int'(a2 / 4)];
      end
      if (wr_ok) mdl[wi] = merged;
      e.rdy = 1'b1;
      e.err = m_err;
    end
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 32'($urandom_range(0, NW*4-1)), 32'($urandom_range(0, NW*4-1)),
           0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic rnd(input bit allow_err);
    logic [31:0] wa, a1, a2;
    wa = 32'($urandom_range(0, NW-1)) * 4;
    if (allow_err && $urandom_range(0, 9) == 0)
      wa = ($urandom_range(0, 1) == 1) ? (wa | 32'($urandom_range(1, 3))) : (wa | 32'h8000_0000);
    a1 = ($urandom_range(0, 3) == 0) ? ((wa & 32'h0000_FFFC) | 32'($urandom_range(0, 3)))
                                      : 32'($urandom_range(0, NW*4-1));
    if (!allow_err && m_oob(a1)) a1 = 32'h0;
    a2 = ($urandom_range(0, 3) == 0) ? a1 : 32'($urandom_range(0, NW*4-1));
    if (allow_err && $urandom_range(0, 15) == 0) a2 = 32'h4000_0000 | 32'($urandom_range(0, 255));
    step(0, a1, a2, 1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("r1_data", bus.mem_r1_data, e.r1);
        chk("r2_data", bus.mem_r2_data, e.r2);
        chk("ready", 32'(bus.mem_ready), 32'(e.rdy));
        chk("err", 32'(bus.mem_err), 32'(e.err));
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    idle(NW + 2);
    // full write then dual read, one address with ignored low bits
    step(0, 0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF);
    step(0, 32'h100, 32'h103, 0, 0, 0, 0);
    step(0, 32'h100, 32'h100, 1, 32'h100, 4'b0101, 32'h11223344);
    step(0, 32'h100, 32'h101, 0, 0, 0, 0);
    // same-cycle write and read of one word
    step(0, 32'h20, 32'h0, 1, 32'h20, 4'hF, 32'hCAFEF00D);
    step(0, 32'h20, 32'h20, 0, 0, 0, 0);
    // zero byte mask on a misaligned address: no-op, no error
    step(0, 32'h0, 32'h0, 1, 32'h42, 4'h0, 32'hFFFFFFFF);
    step(0, 32'h40, 32'h42, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) rnd(0);
    // reset mid-sweep restarts the clear from word 0
    step(0, 0, 0, 1, 32'h100, 4'hF, 32'h12345678);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(8);
    step(1, 0, 0, 1, 32'h104, 4'hF, 32'h55AA55AA);
    idle(NW + 1);
    step(0, 32'h100, 32'h104, 0, 0, 0, 0);
    // illegal accesses
    step(0, 0, 0, 1, 32'h100, 4'hF, 32'hA5A5A5A5);
    step(0, 32'h100, 32'h100, 1, 32'h102, 4'hF, 32'h5555_5555);
    step(0, 32'h100, 32'h4000_0000, 0, 0, 0, 0);
    step(0, 32'h100, 32'h0, 1, 32'h4000_0000, 4'hF, 32'h0);
    idle(4);
    for (int i = 0; i < 300; i++) rnd(1);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(NW + 3);
    for (int i = 0; i < 100; i++) rnd(1);
    idle(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_mem.md
CPU_MEM -- requirements
Module: cpu_mem

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width; capacity is 2^ADDR_W 32-bit words.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_r1_addr  input  32  byte address of read port 1.
REQ-005 mem_r1_data  output  32  registered read data of port 1.
REQ-006 mem_r2_addr  input  32  byte address of read port 2.
REQ-007 mem_r2_data  output  32  registered read data of port 2.
REQ-008 mem_w_enable  input  1  write request strobe.
REQ-009 mem_w_addr  input  32  byte address of the write.
REQ-010 mem_byte_en  input  4  per-byte write enable; bit i selects mem_w_data[8i+7:8i].
REQ-011 mem_w_data  input  32  write data.
REQ-012 mem_ready  output  1  high when memory is initialised and serving requests.
REQ-013 mem_err  output  1  sticky access-error flag.

Function
REQ-014 Word index = addr[ADDR_W+1:2]; an address is out of range when addr[31:ADDR_W+2] is nonzero.
REQ-015 Reads: addr[1:0] ignored; data appears on mem_rN_data exactly one cycle after the address is sampled.
REQ-016 Out-of-range read returns 32'h0 on the next cycle and sets mem_err.
REQ-017 Write: when mem_w_enable is high, in range, and addr[1:0]==0, only bytes with mem_byte_en set are updated at the clock edge.
REQ-018 Write with addr[1:0]!=0 or out of range is dropped and sets mem_err.
REQ-019 mem_w_enable high with mem_byte_en==0 is a no-op, not an error.
REQ-020 Both read ports are independent; identical addresses on both ports return identical data.
REQ-021 Two-state FSM: CLEAR and RUN.
REQ-022 CLEAR: an ADDR_W-bit counter walks 0..2^ADDR_W-1, writing 32'h0 one word per cycle; mem_ready=0; reads return 32'h0; writes dropped without setting mem_err.
REQ-023 CLEAR -> RUN on the cycle after the last word (counter wraps from all-ones); mem_ready rises in that cycle; clear takes exactly 2^ADDR_W cycles.
REQ-024 RUN: normal operation per REQ-015..REQ-020; RUN persists until rst.
REQ-025 mem_err stays set until rst; it is never cleared by a successful access.

Reset
REQ-026 While rst is high: FSM=CLEAR, counter=0, mem_r1_data=0, mem_r2_data=0, mem_ready=0, mem_err=0.
REQ-027 rst asserted mid-clear or mid-RUN restarts the full clear sweep from word 0 after rst falls.
REQ-028 A write presented in the same cycle as rst is dropped.

Configuration
REQ-029 Macro CPU_MEM_BYPASS_EN selects read-during-write behaviour for same-word accesses in RUN.
REQ-030 With CPU_MEM_BYPASS_EN defined: a read of the word being written that cycle returns the merged new data (enabled bytes from mem_w_data, others from old contents).
REQ-031 Without CPU_MEM_BYPASS_EN: such a read returns the old word contents; the new value is visible one cycle later.

Verification
REQ-032 ADDR_W=4, rst 1 cycle then release -> mem_ready low 16 cycles, high on cycle 17; all reads return 0.
REQ-033 RUN, write 0x100 data 0xDEADBEEF be=4'b1111, then read r1=0x100, r2=0x103 -> both return 0xDEADBEEF one cycle later.
REQ-034 Word 0x100 holds 0xDEADBEEF, write data 0x11223344 be=4'b0101 -> read returns 0xDE22BE44.
REQ-035 Write to 0x102 or read of 0x40000000 (ADDR_W=4) -> memory unchanged, read data 0, mem_err=1 and remains 1 until rst.
REQ-036 Same-cycle write 0xCAFEF00D and r1 read of 0x20 over old 0x0 -> 0xCAFEF00D with CPU_MEM_BYPASS_EN, 0x0 without.
REQ-037 rst pulsed at cycle 8 of the clear sweep -> sweep restarts; mem_ready rises 16 cycles after rst falls; previously written data reads 0.
